ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-master arbiter that shares the single-ported byte-write block RAM wrapper between the jedro_1 instruction-fetch port and the load/store port. It sits between the core's memory ports and the RAM wrapper's `stb/we/addr/wdata -> ack/rdata/err` interface. It guarantees one outstanding RAM access at a time and returns each response to its owner. Out-of-range accesses are rejected locally with an error.

## Interface
Parameters:
- `DATA_WIDTH`, 32 (from `jedro_1_defines`): data and address width.
- `MEM_SIZE_WORDS`, 4096: RAM depth; valid byte addresses are `0 .. MEM_SIZE_WORDS*4-1`.

Ports:
- Clock and reset:
  - `clk_i`  in  1  single clock.
  - `rstn_i`  in  1  reset, asynchronous, active-low.
- Instruction port:
  - `iram_stb_i`  in  1  instruction-port request; held high until `iram_ack_o`.
  - `iram_addr_i`  in  DATA_WIDTH  instruction byte address.
  - `iram_rdata_o`  out  DATA_WIDTH  read data; valid with `iram_ack_o`.
  - `iram_ack_o`  out  1  one-cycle completion pulse.
  - `iram_err_o`  out  1  error qualifier, valid with `iram_ack_o`.
- Data port:
  - `dram_stb_i`  in  1  data-port request; held high until `dram_ack_o`.
  - `dram_we_i`  in  4  byte write enables; 0 means read.
  - `dram_addr_i`  in  DATA_WIDTH  data byte address.
  - `dram_wdata_i`  in  DATA_WIDTH  write data.
  - `dram_rdata_o`, `dram_ack_o`, `dram_err_o`: same meaning as the instruction-port equivalents.
- RAM side:
  - `ram_stb_o`  out  1  strobe to RAM.
  - `ram_we_o`  out  4  byte enables to RAM.
  - `ram_addr_o`  out  DATA_WIDTH  address to RAM.
  - `ram_wdata_o`  out  DATA_WIDTH  write data to RAM.
  - `ram_rdata_i`  in  DATA_WIDTH  read data from RAM.
  - `ram_ack_i`  in  1  RAM ack, arrives 1 cycle after `ram_stb_o`.
  - `ram_err_i`  in  1  RAM error.

## Operation
- States:
  - IDLE: no access outstanding.
  - WAIT_I: instruction access outstanding.
  - WAIT_D: data access outstanding.
  - Flag `lerr_q` marks a locally rejected access.
- Grant, in IDLE or in the ack cycle of WAIT_x:
  - Eligible requesters: requesting masters, excluding the master being acked this cycle.
  - Winner chosen per Configuration.
  - In-range winner: RAM fields driven combinationally from the winner; `ram_stb_o=1`; `lerr_q<=0`.
  - Out-of-range winner (addr ≥ MEM_SIZE_WORDS*4): `ram_stb_o=0`; `lerr_q<=1`.
  - Next state is WAIT of the winner. No eligible requester: IDLE.
- RAM field routing:
  - Instruction grant: `ram_we_o=0`, `ram_wdata_o` don't-care.
  - No grant: `ram_stb_o=0`, `ram_we_o=0`.
- WAIT_x completion:
  - `x_ack_o = lerr_q | ram_ack_i`.
  - `x_err_o = lerr_q | ram_err_i`, qualified by ack.
  - No ack seen: state holds.
- `iram_rdata_o = dram_rdata_o = ram_rdata_i` unconditionally. Local-error reads return undefined data.
- A master's `stb` is ignored in its own ack cycle. Each master gets at most one access per 2 cycles. Two alternating masters keep the RAM busy every cycle.
- Write enables pass unchanged; no alignment check.

## Timing
- Reset values while `rstn_i=0`:
  - state IDLE, `lerr_q=0`, `last_q=DATA`.
  - All `*_ack_o`, `*_err_o`, `ram_stb_o`, `ram_we_o` are 0, even with requests pending.
- Reset asserted mid-access: the in-flight response is dropped. The RAM wrapper's ack that follows is ignored because the state is IDLE.
- Latency, uncontended: request high in cycle N → RAM strobe in N → ack in N+1.
- Latency, contended: the loser is granted in the winner's ack cycle, so its ack comes 1 cycle later.
- Out-of-range access: ack and err both in N+1; RAM is never strobed.
- RAM ack arriving in IDLE is ignored.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous eligible requests, grant the master not equal to `last_q`.
  - `last_q` updates on every grant.
  - After reset the instruction port wins first.
- Not defined:
  - Fixed priority, data port always wins.
  - `last_q` logic omitted.

## Test plan
- Single read: preload word 0x10 = 0xDEADBEEF; instr stb with addr 0x40 at cycle 0 → `ram_stb_o` at 0, `iram_ack_o` at 1 with rdata 0xDEADBEEF, `iram_err_o=0`.
- Byte write then read: data we=4'b0010, addr 0x8, wdata 0x0000AB00 onto word 0x11223344 → ack at cycle 1; read at cycle 2 → ack at 3, rdata 0x1122AB44.
- Contention: both stb high at cycle 0, held until acked:
  - With `RAM_ARB_ROUND_ROBIN_EN`: instr acked at 1, data at 2.
  - Without it: data at 1, instr at 2.
  - Both held continuously: grants alternate every cycle.
- Out of range: data read addr 0x4000 with MEM_SIZE_WORDS=4096 → `ram_stb_o` stays 0; `dram_ack_o` and `dram_err_o` both 1 at cycle 1.
- Reset mid-operation: data write granted at cycle 0, `rstn_i` low in cycle 1 → all acks 0 during reset. After release with no requests, state is IDLE and no stray ack occurs.
- Self-ineligibility: instr stb held high continuously with no data requests → `iram_ack_o` pulses at cycles 1, 3, 5; `ram_stb_o` at 0, 2, 4.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between instruction and data masters; RAM_ARB_ROUND_ROBIN_EN selects round-robin over fixed data priority
module ram_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_SIZE_WORDS = 4096
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  iram_stb_i,
  input  logic [DATA_WIDTH-1:0] iram_addr_i,
  output logic [DATA_WIDTH-1:0] iram_rdata_o,
  output logic                  iram_ack_o,
  output logic                  iram_err_o,
  input  logic                  dram_stb_i,
  input  logic [3:0]            dram_we_i,
  input  logic [DATA_WIDTH-1:0] dram_addr_i,
  input  logic [DATA_WIDTH-1:0] dram_wdata_i,
  output logic [DATA_WIDTH-1:0] dram_rdata_o,
  output logic                  dram_ack_o,
  output logic                  dram_err_o,
  output logic                  ram_stb_o,
  output logic [3:0]            ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  input  logic                  ram_ack_i,
  input  logic                  ram_err_i
);
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
  localparam logic [DATA_WIDTH:0] LIMIT = (DATA_WIDTH+1)'(MEM_SIZE_WORDS * 4);
  state_t state_q, state_d;
  logic lerr_q, lerr_d;
  logic i_ack, d_ack, done, i_elig, d_elig, pick_d, gnt, in_range;
  logic [DATA_WIDTH-1:0] addr_sel;
  always_comb begin
    i_ack        = state_q == WAIT_I && (lerr_q || ram_ack_i);
    d_ack        = state_q == WAIT_D && (lerr_q || ram_ack_i);
    done         = state_q == IDLE || i_ack || d_ack;
    i_elig       = iram_stb_i && !i_ack;
    d_elig       = dram_stb_i && !d_ack;
    gnt          = rstn_i && done && (i_elig || d_elig);
    addr_sel     = pick_d ? dram_addr_i : iram_addr_i;
    in_range     = {1'b0, addr_sel} < LIMIT;
    ram_stb_o    = gnt && in_range;
    ram_we_o     = (ram_stb_o && pick_d) ? dram_we_i : 4'b0;
    ram_addr_o   = addr_sel;
    ram_wdata_o  = dram_wdata_i;
    iram_ack_o   = i_ack;
    dram_ack_o   = d_ack;
    iram_err_o   = i_ack && (lerr_q || ram_err_i);
    dram_err_o   = d_ack && (lerr_q || ram_err_i);
    iram_rdata_o = ram_rdata_i;
    dram_rdata_o = ram_rdata_i;
    state_d      = gnt ? (pick_d ? WAIT_D : WAIT_I) : (done ? IDLE : state_q);
    lerr_d       = done ? (gnt && !in_range) : lerr_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q <= IDLE;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lerr_q  <= lerr_d;
    end
`ifdef RAM_ARB_ROUND_ROBIN_EN
  // last_q = 1 means the data port held the most recent grant
  logic last_q, last_d;
  always_comb begin
    pick_d = (i_elig && d_elig) ? !last_q : d_elig;
    last_d = gnt ? pick_d : last_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) last_q <= 1'b1;
    else         last_q <= last_d;
`else
  always_comb pick_d = d_elig;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table-driven cycle checks plus a per-port response scoreboard against a behavioural RAM
module tb_ram_port_arbiter;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rstn_i = 1'b0;
  logic iram_stb_i = 1'b0, dram_stb_i = 1'b0;
  logic [31:0] iram_addr_i = '0, dram_addr_i = '0, dram_wdata_i = '0;
  logic [3:0] dram_we_i = '0;
  logic [31:0] iram_rdata_o, dram_rdata_o, ram_addr_o, ram_wdata_o;
  logic iram_ack_o, iram_err_o, dram_ack_o, dram_err_o, ram_stb_o;
  logic [3:0] ram_we_o;
  logic [31:0] ram_rdata_i = '0;
  logic ram_ack_i = 1'b0, ram_err_i = 1'b0, inj = 1'b0;
  logic [31:0] mem [0:4095];
  logic [31:0] sh [0:4095];
  int n_chk = 0, n_pass = 0;

  typedef struct {
    bit err;
    bit chk;
    logic [31:0] data;
  } sb_t;
  sb_t iq[$], dq[$];

  typedef struct {
    bit istb;
    logic [31:0] iaddr;
    bit dstb;
    logic [3:0] dwe;
    logic [31:0] daddr, dwdata;
    bit inj, e_s, e_ia, e_da, p_i, p_d;
  } vec_t;
  vec_t v[$];

  ram_port_arbiter dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .iram_stb_i(iram_stb_i), .iram_addr_i(iram_addr_i), .iram_rdata_o(iram_rdata_o),
    .iram_ack_o(iram_ack_o), .iram_err_o(iram_err_o),
    .dram_stb_i(dram_stb_i), .dram_we_i(dram_we_i), .dram_addr_i(dram_addr_i),
    .dram_wdata_i(dram_wdata_i), .dram_rdata_o(dram_rdata_o), .dram_ack_o(dram_ack_o),
    .dram_err_o(dram_err_o),
    .ram_stb_o(ram_stb_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
    .ram_err_i(ram_err_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [31:0] rd;
    rd = ram_rdata_i;
    if (ram_stb_o) begin
      rd = mem[ram_addr_o[13:2]];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_addr_o[13:2]][8*b +: 8] = ram_wdata_o[8*b +: 8];
    end
    ram_rdata_i <= rd;
    ram_ack_i   <= ram_stb_o;
    ram_err_i   <= ram_stb_o && inj;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rstn_i && iram_ack_o) begin
      if (iq.size() == 0) begin
        n_chk++;
        $display("FAIL i_ack: got unexpected ack expected none");
      end else begin
        e = iq.pop_front();
        chk("i_err", {31'b0, iram_err_o}, {31'b0, e.err});
        if (e.chk) chk("i_rdata", iram_rdata_o, e.data);
      end
    end
    if (rstn_i && dram_ack_o) begin
      if (dq.size() == 0) begin
        n_chk++;
        $display("FAIL d_ack: got unexpected ack expected none");
      end else begin
        e = dq.pop_front();
        chk("d_err", {31'b0, dram_err_o}, {31'b0, e.err});
        if (e.chk) chk("d_rdata", dram_rdata_o, e.data);
      end
    end
  end

  function automatic vec_t mk(bit istb, logic [31:0] iaddr, bit dstb, logic [3:0] dwe,
                              logic [31:0] daddr, logic [31:0] dwdata, bit inj_, bit e_s,
                              bit e_ia, bit e_da, bit p_i, bit p_d);
    vec_t r;
    r.istb = istb; r.iaddr = iaddr; r.dstb = dstb; r.dwe = dwe; r.daddr = daddr;
    r.dwdata = dwdata; r.inj = inj_; r.e_s = e_s; r.e_ia = e_ia; r.e_da = e_da;
    r.p_i = p_i; r.p_d = p_d;
    return r;
  endfunction

  initial begin
    bit gd, pgd;
    sb_t e;
    for (int j = 0; j < 4096; j++) begin
      mem[j] = 32'h5A5A0000 | j;
      sh[j]  = 32'h5A5A0000 | j;
    end
    mem[16] = 32'hDEADBEEF; sh[16] = 32'hDEADBEEF;
    mem[2]  = 32'h11223344; sh[2]  = 32'h11223344;
    // single read, byte write then read-back
    v.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    v.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 4'b0010, 32'h8, 32'h0000AB00, 0, 1, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 1, 4'b0010, 32'h8, 32'h0000AB00, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 32'h8, 0, 0, 1, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 1, 0, 32'h8, 0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // contention, each held until its own ack
    v.push_back(mk(1, 32'h44, 1, 0, 32'hC, 0, 0, 1, 0, 0, 1, 1));
    v.push_back(mk(1, 32'h44, 1, 0, 32'hC, 0, 0, 1, RR, !RR, 0, 0));
    v.push_back(mk(!RR, 32'h44, RR, 0, 32'hC, 0, 0, 0, !RR, RR, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // both held continuously: grants alternate every cycle
    for (int k = 0; k < 6; k++) begin
      gd  = ((k % 2) == 0) ^ RR;
      pgd = ((k % 2) == 1) ^ RR;
      v.push_back(mk(1, 32'h48, 1, 0, 32'h4C, 0, 0, 1, k > 0 && !pgd, k > 0 && pgd, !gd, gd));
    end
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, !RR, RR, 0, 0));
    // out of range and last in-range word
    v.push_back(mk(0, 0, 1, 0, 32'h4000, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 1, 0, 32'h4000, 0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(1, 32'h3FFC, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    v.push_back(mk(1, 32'h3FFC, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // self-ineligibility: one held request gets every other cycle
    for (int k = 0; k < 6; k++)
      v.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, k % 2 == 0, k % 2 == 1, 0, k % 2 == 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // RAM-reported error
    v.push_back(mk(0, 0, 1, 0, 32'h10, 0, 1, 1, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    iram_stb_i = 1; dram_stb_i = 1; dram_we_i = 4'hF; iram_addr_i = 32'h40; dram_addr_i = 32'h40;
    repeat (2) begin
      @(negedge clk);
      chk("rst_stb", {31'b0, ram_stb_o}, 0);
      chk("rst_we", {28'b0, ram_we_o}, 0);
      chk("rst_iack", {31'b0, iram_ack_o}, 0);
      chk("rst_dack", {31'b0, dram_ack_o}, 0);
    end
    @(posedge clk); #1;
    iram_stb_i = 0; dram_stb_i = 0; dram_we_i = 0; rstn_i = 1;

    for (int r = 0; r < v.size(); r++) begin
      @(posedge clk); #1;
      iram_stb_i = v[r].istb; iram_addr_i = v[r].iaddr;
      dram_stb_i = v[r].dstb; dram_we_i = v[r].dwe;
      dram_addr_i = v[r].daddr; dram_wdata_i = v[r].dwdata; inj = v[r].inj;
      if (v[r].p_i) begin
        e.err = v[r].iaddr >= 32'h4000 || v[r].inj;
        e.chk = !e.err;
        e.data = sh[v[r].iaddr[13:2]];
        iq.push_back(e);
      end
      if (v[r].p_d) begin
        e.err = v[r].daddr >= 32'h4000 || v[r].inj;
        e.chk = !e.err && v[r].dwe == 0;
        e.data = sh[v[r].daddr[13:2]];
        if (!e.err)
          for (int b = 0; b < 4; b++)
            if (v[r].dwe[b]) sh[v[r].daddr[13:2]][8*b +: 8] = v[r].dwdata[8*b +: 8];
        dq.push_back(e);
      end
      @(negedge clk);
      chk($sformatf("r%0d_ram_stb", r), {31'b0, ram_stb_o}, {31'b0, v[r].e_s});
      chk($sformatf("r%0d_iack", r), {31'b0, iram_ack_o}, {31'b0, v[r].e_ia});
      chk($sformatf("r%0d_dack", r), {31'b0, dram_ack_o}, {31'b0, v[r].e_da});
    end

    // reset in the middle of a granted write; the late RAM ack must be ignored
    @(posedge clk); #1;
    dram_stb_i = 1; dram_we_i = 4'hF; dram_addr_i = 32'h100; dram_wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("mid_stb", {31'b0, ram_stb_o}, 1);
    @(posedge clk); #1;
    rstn_i = 0;
    @(negedge clk);
    chk("mid_rst_dack", {31'b0, dram_ack_o}, 0);
    chk("mid_rst_iack", {31'b0, iram_ack_o}, 0);
    chk("mid_rst_stb", {31'b0, ram_stb_o}, 0);
    chk("mid_rst_we", {28'b0, ram_we_o}, 0);
    @(posedge clk); #1;
    dram_stb_i = 0; dram_we_i = 0;
    @(posedge clk); #1;
    rstn_i = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_iack", {31'b0, iram_ack_o}, 0);
      chk("post_rst_dack", {31'b0, dram_ack_o}, 0);
      chk("post_rst_stb", {31'b0, ram_stb_o}, 0);
    end
    chk("i_sb_empty", iq.size(), 0);
    chk("d_sb_empty", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
